// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning path: FSM encoding and parameter defaults.
// Pure declarations; no logic, no latency, no flow control.
package btn_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // 10 ms debounce and 200 ms repeat period at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int CNT_W_DEF           = 20;
    localparam int REPEAT_DELAY_DEF    = 0;
    localparam int REPEAT_RATE_DEF     = 20_000_000;
    localparam int REP_W_DEF           = 26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous board input, reset value 0.
// Latency 2 clk edges; no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Debounces a raw button into a clean level plus one-cycle press/release pulses, with optional auto-repeat.
// Edge reported DEBOUNCE_CYCLES+2 edges after the input settles; no backpressure (pulses are fire-and-forget).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = btn_pkg::CNT_W_DEF,
    parameter int REPEAT_DELAY    = btn_pkg::REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = btn_pkg::REPEAT_RATE_DEF,
    parameter int REP_W           = btn_pkg::REP_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    import btn_pkg::*;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
    localparam bit               REP_EN     = (REPEAT_DELAY > 0);

    logic             btn_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [REP_W-1:0] rep;
    logic             rep_first;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_i),
        .q     (btn_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rep         <= '0;
            rep_first   <= 1'b1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (btn_s) begin
                        state <= ST_PRESS_WAIT;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        rep       <= '0;
                        rep_first <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_s) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                        rep   <= '0;
                    end else if (REP_EN) begin
                        // first repeat waits REPEAT_DELAY, later ones REPEAT_RATE
                        if (rep == (rep_first ? DELAY_LAST : RATE_LAST)) begin
                            btn_press <= 1'b1;
                            rep       <= '0;
                            rep_first <= 1'b0;
                        end else begin
                            rep <= rep + 1'b1;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (btn_s) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        rep       <= '0;
                        rep_first <= 1'b1;
                    end else if (cnt == DB_LAST) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // level is a pure function of the registered state, so it only moves on accepted edges
    assign btn_level = (state == ST_PRESSED) || (state == ST_RELEASE_WAIT);

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: instance 0 without repeat, instance 1 with REPEAT_DELAY=20, REPEAT_RATE=5.
// A run-length model predicts outputs every cycle; directed scenarios pin pulse timing with literal values.
module tb_btn_debounce;

    localparam int D     = 8;
    localparam int RD1   = 20;
    localparam int RATE1 = 5;

    logic       clk;
    logic       rst_n;
    logic       btn_i;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state: btn_i delay line, then per instance level, run length of disagreeing samples, hold time
    bit h1 = 1'b0;
    bit h2 = 1'b0;
    bit m_lvl[2];
    bit m_prs[2];
    bit m_rel[2];
    int m_run[2];
    int m_t[2];

    int pq0[$];
    int pq1[$];
    int rel_n[2];
    int last_rel[2];

    btn_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .REPEAT_DELAY    (0),
        .REPEAT_RATE     (5),
        .REP_W           (6)
    ) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn_i),
        .btn_level   (lvl[0]),
        .btn_press   (prs[0]),
        .btn_release (rel[0])
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .REPEAT_DELAY    (RD1),
        .REPEAT_RATE     (RATE1),
        .REP_W           (6)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn_i),
        .btn_level   (lvl[1]),
        .btn_press   (prs[1]),
        .btn_release (rel[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // An edge is accepted once the synchronised input has disagreed with the level for D+1 edges in a row.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            h1 = 1'b0;
            h2 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_lvl[i] = 1'b0; m_prs[i] = 1'b0; m_rel[i] = 1'b0;
                m_run[i] = 0;    m_t[i]   = 0;
            end
        end else begin
            automatic bit s = h2;
            h2 = h1;
            h1 = btn_i;
            for (int i = 0; i < 2; i++) begin
                automatic int rd   = (i == 1) ? RD1 : 0;
                automatic int rate = (i == 1) ? RATE1 : 1;
                m_prs[i] = 1'b0;
                m_rel[i] = 1'b0;
                if (!m_lvl[i]) begin
                    m_run[i] = s ? m_run[i] + 1 : 0;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = 1'b1; m_prs[i] = 1'b1; m_run[i] = 0; m_t[i] = 0;
                    end
                end else if (!s) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = 1'b0; m_rel[i] = 1'b1; m_run[i] = 0;
                    end
                end else if (m_run[i] > 0) begin
                    m_run[i] = 0;
                    m_t[i]   = 0;
                end else begin
                    m_t[i]++;
                    if (rd > 0 && m_t[i] >= rd && ((m_t[i] - rd) % rate) == 0)
                        m_prs[i] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({lvl[i], prs[i], rel[i]} !== {m_lvl[i], m_prs[i], m_rel[i]}) begin
                errors++;
                $display("FAIL cycle_compare inst%0d cyc %0d: got lvl/press/rel=%b%b%b want %b%b%b",
                         i, cyc, lvl[i], prs[i], rel[i], m_lvl[i], m_prs[i], m_rel[i]);
            end
            if (rel[i] === 1'b1) begin
                rel_n[i]++;
                last_rel[i] = cyc;
            end
        end
        if (prs[0] === 1'b1) pq0.push_back(cyc);
        if (prs[1] === 1'b1) pq1.push_back(cyc);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic hold(input bit v, input int n);
        btn_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_events();
        pq0.delete();
        pq1.delete();
        rel_n    = '{0, 0};
        last_rel = '{0, 0};
    endtask

    initial begin
        int e0;
        int first;
        int off[7];
        off = '{0, 20, 25, 30, 35, 40, 45};
        btn_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({lvl, prs, rel}), 0);
        rst_n = 1'b1;

        // clean press held 40 cycles, then clean release
        clear_events();
        hold(0, 5);
        e0 = cyc + 1;
        hold(1, 40);
        chk("t1_press_count", pq0.size(), 1);
        first = (pq0.size() > 0) ? pq0[0] : -1;
        chk("t1_press_edge", first - e0, 10);
        chk("t1_level_held", int'(lvl[0]), 1);
        chk("t1_no_release", rel_n[0], 0);
        e0 = cyc + 1;
        hold(0, 20);
        chk("t1_release_count", rel_n[0], 1);
        chk("t1_release_edge", last_rel[0] - e0, 10);
        chk("t1_level_low", int'(lvl[0]), 0);

        // press bounce 1x3, 0x2, 1x5, 0x4, then stable
        clear_events();
        hold(1, 3); hold(0, 2); hold(1, 5); hold(0, 4);
        chk("t2_no_pulse_in_bounce", pq0.size(), 0);
        e0 = cyc + 1;
        hold(1, 30);
        chk("t2_press_count", pq0.size(), 1);
        first = (pq0.size() > 0) ? pq0[0] : -1;
        chk("t2_press_edge", first - e0, 10);
        hold(0, 20);

        // release with a 4-cycle glitch back to 1
        clear_events();
        hold(1, 20);
        hold(0, 3); hold(1, 4);
        chk("t3_glitch_level", int'(lvl[0]), 1);
        chk("t3_glitch_no_release", rel_n[0], 0);
        e0 = cyc + 1;
        hold(0, 20);
        chk("t3_press_count", pq0.size(), 1);
        chk("t3_release_count", rel_n[0], 1);
        chk("t3_release_edge", last_rel[0] - e0, 10);
        chk("t3_level_low", int'(lvl[0]), 0);

        // auto-repeat: held 50 cycles after the first pulse, then released
        clear_events();
        e0 = cyc + 1;
        hold(1, 58);
        hold(0, 20);
        chk("t4_repeat_count", pq1.size(), 7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("t4_repeat_edge%0d", k), (k < pq1.size()) ? pq1[k] - e0 : -1, 10 + off[k]);
        chk("t4_norepeat_inst0", pq0.size(), 1);

        // reset during PRESS_WAIT count 5 with the button held through reset release
        clear_events();
        hold(1, 8);
        rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs", int'({lvl, prs, rel}), 0);
        chk("t5_no_pulse_before_reset", pq0.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        hold(1, 20);
        chk("t5_press_count", pq0.size(), 1);
        first = (pq0.size() > 0) ? pq0[0] : -1;
        chk("t5_press_edge", first - e0, 10);
        hold(0, 20);

        // ten press/release cycles: the downstream counter steps once per press and wraps at 10
        clear_events();
        for (int k = 0; k < 10; k++) begin
            hold(1, 15);
            chk($sformatf("t6_btn_cnt%0d", k), pq0.size() % 10, (k + 1) % 10);
            hold(0, 15);
        end
        chk("t6_release_count", rel_n[0], 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Upstream conditioning stage for the push-button input of `pwm_display`. Turns a raw, bouncing, asynchronous button into clean signals: a debounced level, and single-cycle press/release pulses. It synchronises the input, confirms each edge with a stability counter, and optionally auto-repeats the press pulse while the button is held. `btn_press` drives the `btn` input of `pwm_display`, so one physical press yields exactly one duty-step edge.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised cycles needed to accept an edge (10 ms at 100 MHz); legal range ≥ 1.
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `REPEAT_DELAY`, 0: cycles held after the initial press pulse before the first repeat pulse; 0 disables auto-repeat.
- `REPEAT_RATE`, 20_000_000: cycles between subsequent repeat pulses; ignored when REPEAT_DELAY = 0; legal range ≥ 1.
- `REP_W`, 26: repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE).
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_i` input 1: raw button, active-high, asynchronous to `clk`.
- `btn_level` output 1: debounced button state, 1 = pressed.
- `btn_press` output 1: one-cycle pulse on each accepted press and on each repeat.
- `btn_release` output 1: one-cycle pulse on each accepted release.

## Operation
- 2-FF synchroniser on `btn_i` produces `btn_s`. Both flops reset to 0.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- IDLE: if `btn_s`=1, go to PRESS_WAIT and clear the counter.
- PRESS_WAIT:
  - `btn_s`=0: return to IDLE, counter cleared, no pulse.
  - `btn_s`=1 and counter = DEBOUNCE_CYCLES-1: go to PRESSED, assert `btn_press` and `btn_level`.
  - Otherwise: counter+1.
- PRESSED:
  - `btn_s`=0: go to RELEASE_WAIT, counter cleared.
  - Otherwise, if repeat is enabled, run the repeat counter (see Timing).
- RELEASE_WAIT: mirror of PRESS_WAIT.
  - `btn_s`=1: back to PRESSED with no pulse. `btn_level` stays 1. The repeat counter restarts from 0 with the REPEAT_DELAY target.
  - Stable 0 for DEBOUNCE_CYCLES: go to IDLE, pulse `btn_release`, clear `btn_level`.
- `btn_level` changes only on accepted edges. It equals 1 exactly in PRESSED and RELEASE_WAIT.
- `btn_press` and `btn_release` are registered and never high in the same cycle.
- Counters never wrap: each clears on every state change and on every pulse.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0, state IDLE, all counters 0.
- Reset takes effect asynchronously on `rst_n` falling, mid-debounce included. In-progress counts are discarded and no pulse is emitted.
- Press latency: let E0 be the first edge that samples `btn_i`=1, with `btn_i` stable from then on. `btn_press` and `btn_level` rise after edge E0+DEBOUNCE_CYCLES+2. `btn_press` is high for exactly one cycle.
- Release latency: identical, measured from the first edge sampling `btn_i`=0.
- A bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Auto-repeat, counted in PRESSED only:
  - First repeat pulse: REPEAT_DELAY cycles after the initial `btn_press` pulse.
  - Later pulses: every REPEAT_RATE cycles.
  - Leaving PRESSED stops repeats immediately.
- Button held through reset release: the synchroniser loads 1. The press is reported DEBOUNCE_CYCLES+2 edges after the first post-reset edge.

## Structure
- Shared package `btn_pkg`: 2-bit state encoding (IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3) and default-constant localparams.
- Sub-module `sync_2ff` (1-bit, async active-low reset, reset value 0). It is reused for other asynchronous board inputs.
- Everything else lives in `btn_debounce`.

## Test plan
Use DEBOUNCE_CYCLES=8, REPEAT_DELAY=0 unless stated.
- Clean press held 40 cycles: exactly one `btn_press` pulse, after edge E0+10. `btn_level` rises with it. No `btn_release` while held.
- Bounce: 1 for 3, 0 for 2, 1 for 5, 0 for 4, then stable 1. No pulse during the bounce. One `btn_press` pulse 10 edges after the final rising sample.
- Release after a held press, including a 4-cycle glitch back to 1: glitch produces no pulse and `btn_level` stays 1. After a clean release, one `btn_release` pulse 10 edges later and `btn_level`=0.
- Auto-repeat with REPEAT_DELAY=20, REPEAT_RATE=5, held 50 cycles after the first pulse: pulses at +0, +20, +25, +30, +35, +40, +45. Repeats stop on release.
- `rst_n` asserted at PRESS_WAIT count 5: all outputs 0 immediately. After release with `btn_i` still 1, exactly one `btn_press` pulse at the post-reset edge +10.
- 10 clean press/release cycles into `pwm_display`: `btn_cnt` steps 1..9 then wraps to 0, one step per press.
